// File: rtl/codec_init_seq.sv
// codec_init_seq: power-up configuration sequencer for the audio codec.
//
// After reset it waits PWR_WAIT cycles, then walks a fixed 9-entry table of
// codec register writes and hands each one to the I2C engine over a go/rdy
// handshake. NACKed or unaccepted writes are retried up to MAX_RETRY times;
// a write that never completes aborts at once. The I2S path stays muted until
// done is high.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle pulse, re-runs the table from DONE or ERROR
//   i2c_rdy   in   engine idle/ready
//   i2c_nack  in   engine NACK flag, valid in the cycle i2c_rdy rises
//   i2c_go    out  one-cycle command strobe
//   i2c_dev   out  7-bit device address (constant DEV_ADDR)
//   i2c_data  out  {reg[6:0], val[8:0]} payload
//   busy      out  sequence in progress
//   done      out  all entries written successfully
//   err       out  sequence aborted
//   err_idx   out  table index that failed
module codec_init_seq #(
   parameter logic [6:0]  DEV_ADDR  = 7'h1A,
   parameter int unsigned PWR_WAIT  = 50000,
   parameter int unsigned GAP_CYC   = 64,
   parameter int unsigned ACC_TO    = 8,
   parameter int unsigned DONE_TO   = 65535,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        i2c_rdy,
   input  logic        i2c_nack,
   output logic        i2c_go,
   output logic [6:0]  i2c_dev,
   output logic [15:0] i2c_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [3:0]  err_idx
);

   // One shared wait counter, wide enough for the longest of the four waits.
   localparam int unsigned Max1   = (PWR_WAIT > GAP_CYC) ? PWR_WAIT : GAP_CYC;
   localparam int unsigned Max2   = (ACC_TO > DONE_TO) ? ACC_TO : DONE_TO;
   localparam int unsigned CntMax = (Max1 > Max2) ? Max1 : Max2;
   localparam int unsigned CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);
   localparam int unsigned RetW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   // Terminal counts. Each wait ends on the cycle its counter reaches *Last,
   // and the counter never advances past it, so nothing can wrap.
   localparam logic [CntW-1:0] PwrLast  = CntW'(PWR_WAIT);
   localparam logic [CntW-1:0] GapLast  = CntW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
   localparam logic [CntW-1:0] AccLast  = CntW'((ACC_TO == 0) ? 0 : ACC_TO - 1);
   localparam logic [CntW-1:0] DoneLast = CntW'((DONE_TO == 0) ? 0 : DONE_TO - 1);
   localparam logic [RetW-1:0] RetryMax = RetW'(MAX_RETRY);
   localparam logic [3:0]      IdxLast  = 4'd8;

   typedef enum logic [2:0] {
      StPwr,
      StIssue,
      StAccept,
      StXfer,
      StGap,
      StDone,
      StError
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [RetW-1:0] retry_q;
   logic [3:0]      idx_q;
   logic            ok_q;        // last attempt succeeded; GAP then advances idx
   logic            retry_left;

   assign i2c_dev    = DEV_ADDR;
   assign retry_left = (retry_q < RetryMax);

   // Register write table, {reg[6:0], val[8:0]}.
   function automatic logic [15:0] table_entry(input logic [3:0] i);
      logic [15:0] e;
      case (i)
         4'd0:    e = {7'h0F, 9'h000};
         4'd1:    e = {7'h06, 9'h010};
         4'd2:    e = {7'h02, 9'h079};
         4'd3:    e = {7'h03, 9'h079};
         4'd4:    e = {7'h04, 9'h012};
         4'd5:    e = {7'h05, 9'h000};
         4'd6:    e = {7'h07, 9'h002};
         4'd7:    e = {7'h08, 9'h000};
         4'd8:    e = {7'h09, 9'h001};
         default: e = 16'h0000;
      endcase
      return e;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StPwr;
         cnt_q    <= '0;
         retry_q  <= '0;
         idx_q    <= '0;
         ok_q     <= 1'b0;
         i2c_go   <= 1'b0;
         i2c_data <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_idx  <= '0;
      end else begin
         i2c_go <= 1'b0;
         unique case (state_q)
            StPwr: begin
               busy <= 1'b1;
               if (cnt_q >= PwrLast) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  retry_q <= '0;
                  state_q <= StIssue;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StIssue: begin
               if (i2c_rdy) begin
                  i2c_go   <= 1'b1;
                  i2c_data <= table_entry(idx_q);
                  cnt_q    <= '0;
                  state_q  <= StAccept;
               end
            end

            // The first cycle here is the go cycle itself, where rdy is still
            // high; it counts towards the acceptance timeout.
            StAccept: begin
               if (!i2c_rdy) begin
                  cnt_q   <= '0;
                  state_q <= StXfer;
               end else if (cnt_q >= AccLast) begin
                  cnt_q <= '0;
                  if (retry_left) begin
                     retry_q <= retry_q + 1'b1;
                     ok_q    <= 1'b0;
                     state_q <= StGap;
                  end else begin
                     busy    <= 1'b0;
                     err     <= 1'b1;
                     err_idx <= idx_q;
                     state_q <= StError;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StXfer: begin
               if (i2c_rdy) begin
                  cnt_q <= '0;
                  if (!i2c_nack) begin
                     ok_q    <= 1'b1;
                     state_q <= StGap;
                  end else if (retry_left) begin
                     retry_q <= retry_q + 1'b1;
                     ok_q    <= 1'b0;
                     state_q <= StGap;
                  end else begin
                     busy    <= 1'b0;
                     err     <= 1'b1;
                     err_idx <= idx_q;
                     state_q <= StError;
                  end
               end else if (cnt_q >= DoneLast) begin
                  // A hung engine is not retried.
                  cnt_q   <= '0;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  err_idx <= idx_q;
                  state_q <= StError;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StGap: begin
               if (cnt_q >= GapLast) begin
                  cnt_q <= '0;
                  if (ok_q) begin
                     retry_q <= '0;
                     if (idx_q == IdxLast) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                     end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StIssue;
                     end
                  end else begin
                     // Retry: reissue the same entry.
                     state_q <= StIssue;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            StDone, StError: begin
               if (start) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  retry_q <= '0;
                  ok_q    <= 1'b0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  err     <= 1'b0;
                  err_idx <= '0;
                  state_q <= StIssue;
               end
            end

            default: begin
               cnt_q   <= '0;
               state_q <= StPwr;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_codec_init_seq.sv
// tb_codec_init_seq: directed self-checking bench for codec_init_seq.
// A small behavioural I2C engine answers go with rdy low for 30 cycles and
// can be told to NACK a chosen payload, never accept, or never finish.
module tb_codec_init_seq;

   localparam int unsigned PwrWait  = 100;
   localparam int unsigned GapCyc   = 4;
   localparam int unsigned AccTo    = 8;
   localparam int unsigned DoneTo   = 100;
   localparam int unsigned MaxRetry = 3;

   localparam int ModeNormal = 0;
   localparam int ModeNoDrop = 1;
   localparam int ModeNoRise = 2;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic        i2c_rdy;
   logic        i2c_nack;
   logic        i2c_go;
   logic [6:0]  i2c_dev;
   logic [15:0] i2c_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [3:0]  err_idx;

   codec_init_seq #(
      .DEV_ADDR  (7'h1A),
      .PWR_WAIT  (PwrWait),
      .GAP_CYC   (GapCyc),
      .ACC_TO    (AccTo),
      .DONE_TO   (DoneTo),
      .MAX_RETRY (MaxRetry)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .i2c_rdy  (i2c_rdy),
      .i2c_nack (i2c_nack),
      .i2c_go   (i2c_go),
      .i2c_dev  (i2c_dev),
      .i2c_data (i2c_data),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_idx  (err_idx)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycle count since reset release; the first edge after release is 1.
   int cyc;
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // Engine model.
   int          eng_mode     = ModeNormal;
   logic [15:0] nack_payload = 16'hFFFF;
   int          nack_limit   = 0;
   int          e_cnt;
   int          nack_given;
   logic        pend_nack;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         i2c_rdy    <= 1'b1;
         i2c_nack   <= 1'b0;
         e_cnt      <= 0;
         nack_given <= 0;
         pend_nack  <= 1'b0;
      end else if (e_cnt != 0) begin
         e_cnt <= e_cnt - 1;
         if (e_cnt == 1) begin
            i2c_rdy  <= 1'b1;
            i2c_nack <= pend_nack;
         end
      end else if (i2c_go && i2c_rdy && eng_mode != ModeNoDrop) begin
         i2c_rdy  <= 1'b0;
         i2c_nack <= 1'b0;
         e_cnt    <= (eng_mode == ModeNoRise) ? 0 : 30;
         if (i2c_data == nack_payload && nack_given < nack_limit) begin
            pend_nack  <= 1'b1;
            nack_given <= nack_given + 1;
         end else begin
            pend_nack <= 1'b0;
         end
      end
   end

   // Bus monitor: records every go with payload and cycle, and counts
   // protocol violations.
   logic [15:0] go_q[$];
   int          go_cyc_q[$];
   int          viol;
   int          min_sp;
   int          rise_cyc;
   bit          have_rise;
   bit          in_flight;
   logic [15:0] cur_pl;
   logic        rdy_prev;
   logic        go_prev;

   task automatic clear_mon();
      go_q.delete();
      go_cyc_q.delete();
      viol      = 0;
      min_sp    = 1000000;
      have_rise = 1'b0;
      in_flight = 1'b0;
      cur_pl    = '0;
      rdy_prev  = 1'b1;
      go_prev   = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (i2c_go) begin
            if (!i2c_rdy) viol++;
            if (go_prev) viol++;
            go_q.push_back(i2c_data);
            go_cyc_q.push_back(cyc);
            if (have_rise && (cyc - rise_cyc) < min_sp) min_sp = cyc - rise_cyc;
            in_flight = 1'b1;
            cur_pl    = i2c_data;
         end else if (in_flight && i2c_data !== cur_pl) begin
            viol++;
         end
         if (i2c_rdy && !rdy_prev) begin
            rise_cyc  = cyc;
            have_rise = 1'b1;
            in_flight = 1'b0;
         end
         rdy_prev = i2c_rdy;
         go_prev  = i2c_go;
      end
   end

   logic [15:0] exp_pl [9] = '{16'h1E00, 16'h0C10, 16'h0479, 16'h0679, 16'h0812,
                               16'h0A00, 16'h0E02, 16'h1000, 16'h1201};

   function automatic logic [31:0] pl_at(input int i);
      return (i < go_q.size()) ? {16'h0, go_q[i]} : 32'hDEAD_BEEF;
   endfunction

   function automatic int count_pl(input logic [15:0] p);
      int n = 0;
      foreach (go_q[i]) if (go_q[i] == p) n++;
      return n;
   endfunction

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1 clear_mon();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_end(input string tag, input int bound);
      int n = 0;
      while (!(done || err) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_fin"}, 32'(done | err), 32'd1);
   endtask

   task automatic wait_gos(input string tag, input int cnt, input int bound);
      int n = 0;
      while (go_q.size() < cnt && n < bound) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_gos"}, 32'(go_q.size() >= cnt), 32'd1);
   endtask

   initial begin
      int c;
      // Normal run, including reset values and power-up latency.
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_go", 32'(i2c_go), 0);
      check_eq("rst_data", 32'(i2c_data), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_erridx", 32'(err_idx), 0);
      check_eq("dev", 32'(i2c_dev), 32'h1A);
      release_reset();
      @(negedge clk);
      check_eq("busy_first", 32'(busy), 1);
      wait_end("run", 3000);
      check_eq("run_done", 32'(done), 1);
      check_eq("run_err", 32'(err), 0);
      check_eq("run_busy", 32'(busy), 0);
      check_eq("run_ngo", go_q.size(), 9);
      for (int i = 0; i < 9; i++) check_eq($sformatf("run_pl%0d", i), pl_at(i), 32'(exp_pl[i]));
      check_eq("run_first_go", (go_cyc_q.size() > 0) ? go_cyc_q[0] : -1, PwrWait + 2);
      check_eq("run_viol", viol, 0);
      check_eq("run_spacing", 32'(min_sp >= GapCyc + 1), 1);

      // Entry 2 NACKed twice, then accepted.
      rst = 1'b0;
      eng_mode = ModeNormal; nack_payload = 16'h0479; nack_limit = 2;
      release_reset();
      wait_end("nack2", 3000);
      check_eq("nack2_done", 32'(done), 1);
      check_eq("nack2_err", 32'(err), 0);
      check_eq("nack2_ent2", count_pl(16'h0479), 3);
      check_eq("nack2_ngo", go_q.size(), 11);
      check_eq("nack2_viol", viol, 0);

      // start from DONE reruns at once; a mid-run start is ignored.
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 clear_mon();
      @(negedge clk);
      start = 1'b1;
      c = cyc;
      @(negedge clk);
      start = 1'b0;
      check_eq("rerun_done_clr", 32'(done), 0);
      check_eq("rerun_busy", 32'(busy), 1);
      wait_gos("rerun", 3, 1000);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_end("rerun", 3000);
      check_eq("rerun_lat", (go_cyc_q.size() > 0) ? go_cyc_q[0] - c : -1, 2);
      check_eq("rerun_ngo", go_q.size(), 9);
      check_eq("rerun_pl0", pl_at(0), 32'h1E00);
      check_eq("rerun_pl8", pl_at(8), 32'h1201);
      check_eq("rerun_ok", 32'({done, err}), 32'b10);

      // Entry 4 always NACKs: four attempts then error.
      rst = 1'b0;
      eng_mode = ModeNormal; nack_payload = 16'h0812; nack_limit = 255;
      release_reset();
      wait_end("nack4", 3000);
      check_eq("nack4_err", 32'(err), 1);
      check_eq("nack4_done", 32'(done), 0);
      check_eq("nack4_busy", 32'(busy), 0);
      check_eq("nack4_idx", 32'(err_idx), 4);
      check_eq("nack4_tries", count_pl(16'h0812), 4);
      repeat (150) @(negedge clk);
      check_eq("nack4_ngo", go_q.size(), 8);

      // Engine never accepts.
      rst = 1'b0;
      eng_mode = ModeNoDrop; nack_limit = 0;
      release_reset();
      wait_end("nodrop", 2000);
      check_eq("nodrop_err", 32'(err), 1);
      check_eq("nodrop_idx", 32'(err_idx), 0);
      check_eq("nodrop_ngo", go_q.size(), 4);
      check_eq("nodrop_per1", (go_cyc_q.size() > 1) ? go_cyc_q[1] - go_cyc_q[0] : -1,
               AccTo + GapCyc + 1);
      check_eq("nodrop_per3", (go_cyc_q.size() > 3) ? go_cyc_q[3] - go_cyc_q[2] : -1,
               AccTo + GapCyc + 1);

      // Engine accepts but never finishes: no retry.
      rst = 1'b0;
      eng_mode = ModeNoRise;
      release_reset();
      wait_end("norise", 2000);
      check_eq("norise_err", 32'(err), 1);
      check_eq("norise_idx", 32'(err_idx), 0);
      check_eq("norise_ngo", go_q.size(), 1);

      // Reset during XFER of entry 5.
      rst = 1'b0;
      eng_mode = ModeNormal;
      release_reset();
      wait_gos("rstx", 6, 2000);
      repeat (5) @(negedge clk);
      check_eq("rstx_pre_data", 32'(i2c_data), 32'h0A00);
      check_eq("rstx_pre_rdy", 32'(i2c_rdy), 0);
      #2 rst = 1'b0;
      #1;
      check_eq("rstx_data", 32'(i2c_data), 0);
      check_eq("rstx_busy", 32'(busy), 0);
      check_eq("rstx_go", 32'(i2c_go), 0);
      release_reset();
      wait_end("rstx", 3000);
      check_eq("rstx_done", 32'(done), 1);
      check_eq("rstx_ngo", go_q.size(), 9);
      check_eq("rstx_pl0", pl_at(0), 32'h1E00);
      check_eq("rstx_first_go", (go_cyc_q.size() > 0) ? go_cyc_q[0] : -1, PwrWait + 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/codec_init_seq.md
# codec_init_seq

Power-up configuration sequencer for the audio codec. After reset it waits a fixed power-settle time, then walks a built-in table of register writes and hands each one to the I2C state machine over its `go`/`rdy` handshake. It retries NACKed or unaccepted writes and reports completion or failure. It sits directly upstream of the I2C engine and gates the I2S path, which must stay muted until `done` is high.

## Interface
- `DEV_ADDR`, default 7'h1A: 7-bit codec I2C address, driven constantly on `i2c_dev`.
- `PWR_WAIT`, default 50000: cycles to wait after reset release before the first write (1 ms at 50 MHz).
- `GAP_CYC`, default 64: idle cycles between consecutive writes.
- `ACC_TO`, default 8: cycles allowed for `i2c_rdy` to fall after `i2c_go`.
- `DONE_TO`, default 65535: cycles allowed for `i2c_rdy` to rise after acceptance.
- `MAX_RETRY`, default 3: retries per entry before error.
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-low reset.
- `start` in, 1: one-cycle pulse; re-runs the table from index 0 when idle in DONE or ERROR.
- `i2c_rdy` in, 1: engine idle/ready; high when the engine can accept a command.
- `i2c_nack` in, 1: engine NACK flag; valid in the cycle `i2c_rdy` rises.
- `i2c_go` out, 1: one-cycle command strobe.
- `i2c_dev` out, 7: device address (constant `DEV_ADDR`).
- `i2c_data` out, 16: {reg[6:0], val[8:0]} payload.
- `busy` out, 1: sequence in progress.
- `done` out, 1: all entries written successfully.
- `err` out, 1: sequence aborted.
- `err_idx` out, 4: table index that failed.

## Operation
- Table, 9 entries, indices 0..8, listed as {reg, val}: {0x0F,0x000}, {0x06,0x010}, {0x02,0x079}, {0x03,0x079}, {0x04,0x012}, {0x05,0x000}, {0x07,0x002}, {0x08,0x000}, {0x09,0x001}.
- `i2c_data` = {reg, val}; for example, entry 8 gives 16'h1201.
- States:
  - PWR: counts `PWR_WAIT` cycles, then goes to ISSUE with idx=0 and retry=0.
  - ISSUE: waits for `i2c_rdy`=1. Loads `i2c_data`, pulses `i2c_go` for one cycle, goes to ACCEPT.
  - ACCEPT: if `i2c_rdy` falls, go to XFER. If `ACC_TO` cycles pass without a fall, it is a retry event.
  - XFER: when `i2c_rdy` rises, `i2c_nack`=0 means success and goes to GAP; `i2c_nack`=1 is a retry event. If `DONE_TO` cycles pass without a rise, go to ERROR immediately (no retry).
  - Retry event: if retry < `MAX_RETRY`, retry++ and go to GAP, then reissue the same idx. Otherwise go to ERROR.
  - GAP: counts `GAP_CYC` cycles. On success, idx++ and retry=0; idx==9 goes to DONE, else to ISSUE.
  - DONE / ERROR: hold. A `start` pulse goes to ISSUE with idx=0 and retry=0, clears `done`/`err`, and skips PWR.
- `start` is ignored in PWR, ISSUE, ACCEPT, XFER and GAP.
- `err_idx` latches idx on entry to ERROR and holds until the next `start`.
- Counters are sized for their parameter and saturate; no wrap is permitted.

## Timing
- Reset (rst=0) values, taking effect immediately and asynchronously: `i2c_go`=0, `i2c_data`=0, `busy`=0, `done`=0, `err`=0, `err_idx`=0. State is PWR with counter 0.
- After reset release, `busy`=1 from the first clock edge.
- If `i2c_rdy` is already high, the first `i2c_go` occurs `PWR_WAIT`+1 cycles after the first edge.
- `i2c_data` is valid in the same cycle as `i2c_go` and is held unchanged until the write's `i2c_rdy` rise.
- `i2c_go` is never high on two consecutive cycles and is never asserted while `i2c_rdy`=0.
- Back-to-back writes are spaced by at least `GAP_CYC`+1 cycles, measured from the `i2c_rdy` rise to the next `i2c_go`.
- `done`/`err` assert in the cycle after the final GAP count (DONE) or after the failing event (ERROR). `busy` deasserts in the same cycle.
- Reset asserted mid-transfer aborts immediately. The sequence restarts from PWR; the engine is reset by the same `rst`.

## Test plan
- Normal run with `PWR_WAIT`=100, `GAP_CYC`=4, and an engine model where rdy drops 1 cycle after go and rises 30 cycles later with nack=0 -> exactly 9 go pulses; payloads in order 16'h1E00, 0C10, 0479, 0679, 0812, 0A00, 0E02, 1000, 1201; `done`=1, `err`=0.
- NACK on entry 2 for the first two attempts -> entry 2 is issued 3 times; the sequence completes with `done`=1.
- Entry 4 always NACKs with `MAX_RETRY`=3 -> 4 attempts, then `err`=1, `err_idx`=4, `busy`=0, and no further go pulses.
- Engine never drops rdy -> go is reissued every `ACC_TO`+`GAP_CYC`+1 cycles, 4 total attempts; then `err`=1, `err_idx`=0.
- `start` pulse while in DONE -> immediate rerun with no PWR wait and 9 more writes. A `start` pulse applied mid-sequence has no effect.
- Reset pulsed low during XFER of entry 5 -> outputs return to zero at once; the full run restarts at entry 0 after `PWR_WAIT`.
